// File: rtl/data_mem_resp_pkg.sv
// Shared constants for the data memory responder: default geometry and the
// bit positions used in the error flag vector.
package data_mem_resp_pkg;
  localparam int DEF_ADDR_WIDTH   = 8;
  localparam int DEF_CNT_WIDTH    = 16;
  localparam int DATA_W           = 32;
  localparam int ERR_MISALIGN_BIT = 0;
  localparam int ERR_RANGE_BIT    = 1;

  typedef logic [1:0] err_vec_t;
endpackage

// File: rtl/data_mem_resp_ram_array.sv
// Word storage with a synchronous write and a registered write-first read port.
// Only the read register is reset; array contents survive reset.
module mem_ram_array
  import data_mem_resp_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we,
  input  logic                  re,
  input  logic                  clr,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_W-1:0]     wdata,
  output logic [DATA_W-1:0]     rdata
);

  logic [DATA_W-1:0] mem_q [2**ADDR_WIDTH];
  logic [DATA_W-1:0] rdata_d;
  logic [DATA_W-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[addr] <= wdata;
    end
  end

  // Same-cycle write to the read address forwards the incoming word.
  always_comb begin
    rdata_d = rdata_q;
    if (clr) begin
      rdata_d = '0;
    end else if (re) begin
      rdata_d = we ? wdata : mem_q[addr];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata_q <= '0;
    end else begin
      rdata_q <= rdata_d;
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/data_mem_resp.sv
// Core-facing data memory: validates byte addresses, keeps sticky error flags
// and saturating access counters, and wraps the word array.
module data_mem_resp
  import data_mem_resp_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int CNT_WIDTH  = DEF_CNT_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 mem_ren,
  input  logic                 mem_wen,
  input  logic [31:0]          mem_addr,
  input  logic [31:0]          mem_dout,
  output logic [31:0]          mem_din,
  output logic                 rd_valid,
  output logic                 err_misalign,
  output logic                 err_range,
  output logic [CNT_WIDTH-1:0] rd_count,
  output logic [CNT_WIDTH-1:0] wr_count
);

  logic                  accept;
  logic                  rd_acc;
  logic                  wr_acc;
  logic                  rd_rej;
  err_vec_t              err_hit;
  err_vec_t              err_d;
  err_vec_t              err_q;
  logic                  rd_valid_d;
  logic                  rd_valid_q;
  logic [CNT_WIDTH-1:0]  rd_count_d;
  logic [CNT_WIDTH-1:0]  rd_count_q;
  logic [CNT_WIDTH-1:0]  wr_count_d;
  logic [CNT_WIDTH-1:0]  wr_count_q;

  always_comb begin
    err_hit                   = '0;
    err_hit[ERR_MISALIGN_BIT] = (mem_addr[1:0] != 2'b00);
    err_hit[ERR_RANGE_BIT]    = (mem_addr[31:ADDR_WIDTH+2] != '0);
    accept = (err_hit == '0);
    rd_acc = mem_ren & accept;
    wr_acc = mem_wen & accept;
    rd_rej = mem_ren & ~accept;
  end

  always_comb begin
    err_d      = err_q;
    rd_valid_d = mem_ren;
    rd_count_d = rd_count_q;
    wr_count_d = wr_count_q;
    if (mem_ren | mem_wen) begin
      err_d = err_q | err_hit;
    end
    if (rd_acc && (rd_count_q != '1)) begin
      rd_count_d = rd_count_q + CNT_WIDTH'(1);
    end
    if (wr_acc && (wr_count_q != '1)) begin
      wr_count_d = wr_count_q + CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_q      <= '0;
      rd_valid_q <= 1'b0;
      rd_count_q <= '0;
      wr_count_q <= '0;
    end else begin
      err_q      <= err_d;
      rd_valid_q <= rd_valid_d;
      rd_count_q <= rd_count_d;
      wr_count_q <= wr_count_d;
    end
  end

  // The array write port has no reset, so a write overlapping reset is gated here.
  mem_ram_array #(
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_ram (
    .clk  (clk),
    .rst  (rst),
    .we   (wr_acc & ~rst),
    .re   (rd_acc),
    .clr  (rd_rej),
    .addr (mem_addr[ADDR_WIDTH+1:2]),
    .wdata(mem_dout),
    .rdata(mem_din)
  );

  assign rd_valid     = rd_valid_q;
  assign err_misalign = err_q[ERR_MISALIGN_BIT];
  assign err_range    = err_q[ERR_RANGE_BIT];
  assign rd_count     = rd_count_q;
  assign wr_count     = wr_count_q;

endmodule

// File: doc/data_mem_resp.md
DATA_MEM_RESP -- requirements
Module: data_mem_resp

Interface
REQ-001 Parameter ADDR_WIDTH, default 8, is the word-address width; the array holds 2^ADDR_WIDTH 32-bit words.
REQ-002 Parameter CNT_WIDTH, default 16, is the width of each access counter.
REQ-003 clk  input  1  main clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset; asynchronous, active-high.
REQ-005 mem_ren  input  1  read request from the core memory port.
REQ-006 mem_wen  input  1  write request from the core memory port.
REQ-007 mem_addr  input  32  byte address from the core.
REQ-008 mem_dout  input  32  write data from the core.
REQ-009 mem_din  output  32  read data returned to the core.
REQ-010 rd_valid  output  1  one-cycle pulse: mem_din carries data for the previous cycle's read.
REQ-011 err_misalign  output  1  sticky flag for an access with mem_addr[1:0] != 0.
REQ-012 err_range  output  1  sticky flag for an access with mem_addr[31:ADDR_WIDTH+2] != 0.
REQ-013 rd_count  output  CNT_WIDTH  number of accepted reads.
REQ-014 wr_count  output  CNT_WIDTH  number of accepted writes.

Function
REQ-015 Word index SHALL be mem_addr[ADDR_WIDTH+1:2]; an access is accepted only when it is neither misaligned nor out of range.
REQ-016 An accepted write SHALL update the array at the rising edge of the cycle in which mem_wen=1.
REQ-017 An accepted read SHALL register the addressed word into mem_din at the rising edge; latency is 1 cycle, and rd_valid=1 in the following cycle only.
REQ-018 mem_din SHALL hold its value until the next accepted read or rejected read.
REQ-019 If mem_ren and mem_wen are both 1 to the same accepted address, the read SHALL return mem_dout (write-first).
REQ-020 A rejected access SHALL suppress the write and leave the array unchanged; a rejected read SHALL load mem_din with 0 and pulse rd_valid.
REQ-021 Any rejected access SHALL set the matching error flag(s); both flags may set in the same cycle; flags clear only on reset.
REQ-022 rd_count/wr_count SHALL increment by 1 per accepted read/write and saturate at all-ones (no wrap).
REQ-023 A cycle with mem_ren=mem_wen=0 SHALL change no state except clearing rd_valid.

Reset
REQ-024 While rst=1: mem_din=0, rd_valid=0, err_misalign=0, err_range=0, rd_count=0, wr_count=0, applied asynchronously.
REQ-025 Array contents SHALL NOT be affected by reset.
REQ-026 A request coinciding with rst=1 SHALL be ignored: no write, no count, no flag.

Structure
REQ-027 Shared package SHALL hold default ADDR_WIDTH and CNT_WIDTH constants and the error-bit encoding (bit0 misalign, bit1 range).
REQ-028 The storage SHALL be a sub-module mem_ram_array (single-port sync write, registered write-first read); address checks, counters and flags stay in data_mem_resp.

Verification
REQ-029 Write 0xDEADBEEF to 0x10, then read 0x10 -> next cycle mem_din=0xDEADBEEF, rd_valid=1, wr_count=1, rd_count=1.
REQ-030 ren=wen=1, addr 0x20, mem_dout=0x12345678 -> next cycle mem_din=0x12345678; a later read of 0x20 also returns 0x12345678.
REQ-031 Write to 0x22 -> err_misalign=1, word 0x20 unchanged, wr_count unchanged; flag holds until rst.
REQ-032 Read 0x400 with ADDR_WIDTH=8 -> err_range=1, mem_din=0, rd_valid=1, rd_count unchanged.
REQ-033 2^CNT_WIDTH+3 accepted reads -> rd_count stays at 0xFFFF.
REQ-034 Assert rst mid-burst -> outputs zero immediately without a clock edge; previously written words still read back correctly after release.
